// File: rtl/traffic_sequencer_if.sv
// traffic_sequencer_if: settings and run control in, light drive and display status out
interface traffic_sequencer_if;
    logic [1:0] sim_state;
    logic [7:0] n_duration;
    logic [7:0] s_duration;
    logic [7:0] w_duration;
    logic [7:0] e_duration;
    logic [7:0] yellow_duration;
    logic [7:0] red_holding;
    logic [2:0] n_light;
    logic [2:0] s_light;
    logic [2:0] w_light;
    logic [2:0] e_light;
    logic [3:0] phase;
    logic [7:0] remaining;
    logic       running;
    modport master (
        output sim_state, n_duration, s_duration, w_duration, e_duration, yellow_duration, red_holding,
        input  n_light, s_light, w_light, e_light, phase, remaining, running
    );
    modport slave (
        input  sim_state, n_duration, s_duration, w_duration, e_duration, yellow_duration, red_holding,
        output n_light, s_light, w_light, e_light, phase, remaining, running
    );
endinterface

// File: rtl/traffic_sequencer.sv
// traffic_sequencer: four-way N/S/W/E light cycle with yellow and all-red hold, paced by a 1 s tick
module traffic_sequencer #(
    parameter int TICK_CYCLES = 100_000_000
) (
    input logic                clk,
    input logic                reset,
    traffic_sequencer_if.slave bus
);
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_CYCLES - 1);
    typedef enum logic [3:0] {
        N_GREEN = 4'd0, N_YEL = 4'd1, N_HOLD = 4'd2,
        S_GREEN = 4'd3, S_YEL = 4'd4, S_HOLD = 4'd5,
        W_GREEN = 4'd6, W_YEL = 4'd7, W_HOLD = 4'd8,
        E_GREEN = 4'd9, E_YEL = 4'd10, E_HOLD = 4'd11,
        IDLE    = 4'd15
    } phase_t;
    phase_t          r_phase, w_phase_nx;
    logic [7:0]      r_remaining, w_remaining_nx;
    logic [PW-1:0]   r_presc, w_presc_nx;
    logic [3:0][2:0] r_lights, w_lights;
    logic            r_running, w_running_nx;
    logic [7:0]      w_raw, w_load;
    logic            w_stop, w_play, w_tick, w_illegal;
    assign w_stop    = bus.sim_state == 2'd0 || bus.sim_state == 2'd3;
    assign w_play    = bus.sim_state == 2'd1;
    assign w_tick    = r_presc == LAST;
    assign w_illegal = r_phase > E_HOLD && r_phase != IDLE;
    // Next phase, countdown, prescaler, duration load on phase entry and light decode
    always_comb begin
        w_phase_nx     = r_phase;
        w_remaining_nx = r_remaining;
        w_presc_nx     = r_presc;
        if (w_stop || w_illegal) begin
            w_phase_nx     = IDLE;
            w_remaining_nx = 8'd0;
            w_presc_nx     = '0;
        end else if (w_play && r_phase == IDLE) begin
            w_phase_nx = N_GREEN;
            w_presc_nx = '0;
        end else if (w_play) begin
            w_presc_nx = w_tick ? '0 : r_presc + 1'b1;
            if (w_tick && r_remaining > 8'd1)
                w_remaining_nx = r_remaining - 8'd1;
            else if (w_tick)
                w_phase_nx = (r_phase == E_HOLD) ? N_GREEN : phase_t'(r_phase + 4'd1);
        end
        w_raw = (w_phase_nx == N_GREEN) ? bus.n_duration :
                (w_phase_nx == S_GREEN) ? bus.s_duration :
                (w_phase_nx == W_GREEN) ? bus.w_duration :
                (w_phase_nx == E_GREEN) ? bus.e_duration :
                (w_phase_nx == N_YEL || w_phase_nx == S_YEL ||
                 w_phase_nx == W_YEL || w_phase_nx == E_YEL) ? bus.yellow_duration :
                bus.red_holding;
        w_load = (w_raw == 8'd0) ? 8'd1 : w_raw;
        if (w_phase_nx != r_phase && w_phase_nx != IDLE)
            w_remaining_nx = w_load;
        for (int d = 0; d < 4; d++)
            w_lights[d] = (w_phase_nx == 4'(3 * d))     ? 3'b001 :
                          (w_phase_nx == 4'(3 * d + 1)) ? 3'b010 : 3'b100;
        w_running_nx = w_play && w_phase_nx != IDLE;
    end
    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase     <= IDLE;
            r_remaining <= 8'd0;
            r_presc     <= '0;
            r_lights    <= {4{3'b100}};
            r_running   <= 1'b0;
        end else begin
            r_phase     <= w_phase_nx;
            r_remaining <= w_remaining_nx;
            r_presc     <= w_presc_nx;
            r_lights    <= w_lights;
            r_running   <= w_running_nx;
        end
    end
    assign bus.phase     = r_phase;
    assign bus.remaining = r_remaining;
    assign bus.running   = r_running;
    assign bus.n_light   = r_lights[0];
    assign bus.s_light   = r_lights[1];
    assign bus.w_light   = r_lights[2];
    assign bus.e_light   = r_lights[3];
endmodule

// File: doc/traffic_sequencer.md
# traffic_sequencer

Consumer of the settings and run-control outputs produced by the front-panel menu logic. Runs the four-way intersection light cycle, N → S → W → E, with a yellow phase and an all-red hold after each green. Advances on a 1-second tick derived from `clk`. Provides per-direction light drive, the current phase and the remaining seconds for the display path.

## Interface
- `TICK_CYCLES`, default 100_000_000: `clk` cycles per 1-second tick. The bench uses 4.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high.
- `sim_state` input 2: run control. 0 = STOP, 1 = PLAY, 2 = PAUSE, 3 = treated as STOP.
- `n_duration`, `s_duration`, `w_duration`, `e_duration` input 8 each: green time in seconds.
- `yellow_duration` input 8: yellow time in seconds, shared by all directions.
- `red_holding` input 8: all-red hold in seconds after every yellow.
- `n_light`, `s_light`, `w_light`, `e_light` output 3 each: {red, yellow, green}, one-hot.
- `phase` output 4: current phase code.
- `remaining` output 8: seconds left in the current phase, including the current second.
- `running` output 1: high while in PLAY and not IDLE.

## Operation
- Phase codes:
  - 0 N_GREEN, 1 N_YEL, 2 N_HOLD
  - 3 S_GREEN, 4 S_YEL, 5 S_HOLD
  - 6 W_GREEN, 7 W_YEL, 8 W_HOLD
  - 9 E_GREEN, 10 E_YEL, 11 E_HOLD
  - 15 IDLE. Codes 12–14 are unused; if reached, the block forces IDLE.
- Sequence is 0→1→…→11→0, repeating indefinitely.
- Light mapping:
  - X_GREEN: X = 001, others 100.
  - X_YEL: X = 010, others 100.
  - X_HOLD and IDLE: all 100.
- Duration load:
  - On entry to a phase, `remaining` loads the matching input: green uses that direction's duration, yellow uses `yellow_duration`, hold uses `red_holding`.
  - A value of 0 loads as 1. Values are not clamped above; the 8-bit range is honoured.
  - Inputs are sampled only at phase entry. Changes mid-phase take effect at the next entry of that phase.
- Run control is sampled every cycle:
  - STOP (or 3), from any phase: go to IDLE, `remaining` = 0, prescaler = 0.
  - PLAY while IDLE: enter N_GREEN with `remaining` = `n_duration` (0→1) and prescaler = 0.
  - PLAY while not IDLE: prescaler counts.
  - PAUSE: prescaler, `phase`, `remaining` and lights all hold. PAUSE while IDLE stays IDLE.
  - PLAY after PAUSE resumes from the held prescaler count. No partial second is lost or restarted.
- Prescaler:
  - Counts 0..TICK_CYCLES−1 while in PLAY and not IDLE.
  - Tick = count equals TICK_CYCLES−1; the count wraps to 0 on the same edge.
- On tick:
  - If `remaining` > 1, decrement it.
  - If `remaining` == 1, advance to the next phase and load its duration in the same edge.
- `running` = (sim_state == PLAY) && phase != IDLE, registered.

## Timing
- All outputs are registered.
- Reset values:
  - `phase` = 15.
  - `remaining` = 0.
  - All lights = 100.
  - `running` = 0.
  - Prescaler = 0.
- Reset asserted mid-operation returns all of the above immediately and asynchronously.
- PLAY start: `sim_state` goes to 1 while IDLE at edge k → `phase` = 0 and `remaining` = D after edge k.
- The first tick occurs at edge k + TICK_CYCLES.
- A phase of duration D lasts exactly D × TICK_CYCLES cycles of PLAY time. PAUSE cycles are excluded.
- Phase change, new `remaining` and new lights update on the same edge. There is no intermediate cycle.
- STOP takes effect on the next edge, including on the same edge as a tick. STOP has priority over the tick.
- PAUSE on a tick edge: the tick is suppressed; the prescaler holds at TICK_CYCLES−1. The tick fires on the first PLAY cycle after resuming.

## Test plan
All scenarios use TICK_CYCLES = 4.

1. **Reset state:** assert reset → `phase` = 15, all lights = 100, `remaining` = 0, `running` = 0.
2. **Full cycle:** N/S/W/E = 2, yellow = 1, hold = 1, PLAY from IDLE → `phase` 0 for 8 cycles (`remaining` 2→1), then phase 1 for 4 cycles, phase 2 for 4 cycles, then phase 3, continuing through 11 and back to 0. Total 64 cycles per cycle. `n_light` = 001 during phase 0, 010 during phase 1.
3. **Pause mid-second:** PAUSE 2 cycles after a tick, hold 10 cycles, then PLAY → the next tick arrives 2 PLAY cycles later. `phase`, `remaining` and lights are unchanged throughout the pause.
4. **Stop mid-phase:** STOP during phase 4 with `remaining` = 3 → next edge `phase` = 15, `remaining` = 0, all lights = 100. A following PLAY restarts at phase 0 with `remaining` = `n_duration`.
5. **Late setting change and zero load:** change `s_duration` 2→5 during phase 0 → phase 3 loads 5. Setting `yellow_duration` = 0 → each yellow lasts 4 cycles (loaded as 1).
6. **Illegal control value:** `sim_state` = 3 during PLAY → behaves as STOP. PAUSE while IDLE → stays in phase 15 with `running` = 0.
